// File: rtl/cluster_pwr_pkg.sv
// cluster_pwr_pkg: shared types for the cluster power sequencer.
// States, default cycle counts and the registered output bundle.
package cluster_pwr_pkg;

   localparam int unsigned DEF_CNT_WIDTH      = 8;
   localparam int unsigned DEF_ISO_CYCLES     = 4;
   localparam int unsigned DEF_RST_CYCLES     = 8;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 200;

   typedef enum logic [3:0] {
      OFF,
      PWR_ON,
      CLK_ON,
      RST_HOLD,
      ON,
      RST_ASSERT,
      ISO_ON,
      PWR_OFF,
      ERROR
   } cluster_pwr_state_e;

   typedef struct packed {
      logic pwr_en;
      logic iso;
      logic clk_en;
      logic rstn;
      logic fetch;
      logic busy;
      logic err;
   } cluster_pwr_out_t;

   localparam cluster_pwr_out_t OUT_RESET = '{
      pwr_en : 1'b0,
      iso    : 1'b1,
      clk_en : 1'b0,
      rstn   : 1'b0,
      fetch  : 1'b0,
      busy   : 1'b0,
      err    : 1'b0
   };

   // Static per-state output levels; ON's rstn/fetch
   // come from software and are patched in by the top.
   function automatic cluster_pwr_out_t state_outputs(
      input cluster_pwr_state_e s
   );
      cluster_pwr_out_t o;
      o = OUT_RESET;
      unique case (s)
         OFF: begin
         end
         PWR_ON: begin
            o.pwr_en = 1'b1;
            o.busy   = 1'b1;
         end
         CLK_ON: begin
            o.pwr_en = 1'b1;
            o.clk_en = 1'b1;
            o.busy   = 1'b1;
         end
         RST_HOLD: begin
            o.pwr_en = 1'b1;
            o.iso    = 1'b0;
            o.clk_en = 1'b1;
            o.busy   = 1'b1;
         end
         ON: begin
            o.pwr_en = 1'b1;
            o.iso    = 1'b0;
            o.clk_en = 1'b1;
         end
         RST_ASSERT: begin
            o.pwr_en = 1'b1;
            o.iso    = 1'b0;
            o.clk_en = 1'b1;
            o.busy   = 1'b1;
         end
         ISO_ON: begin
            o.pwr_en = 1'b1;
            o.busy   = 1'b1;
         end
         PWR_OFF: begin
            o.busy   = 1'b1;
         end
         ERROR: begin
            o.err    = 1'b1;
         end
         default: begin
         end
      endcase
      return o;
   endfunction

endpackage

// File: rtl/cluster_pwr_seq_timer.sv
// cluster_pwr_timer: loadable down-counter for sequencer delays.
// A load of 0 behaves as a load of 1 (single-cycle wait).
module cluster_pwr_timer #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] value,
   output logic                 done
);

   logic [CNT_WIDTH-1:0] cnt_q;

   // Load on state entry, then count down and park at 0.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= (value == '0) ? CNT_WIDTH'(1) : value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_WIDTH'(1);
      end
   end

   assign done = (cnt_q == CNT_WIDTH'(1));

endmodule

// File: rtl/cluster_pwr_seq.sv
// cluster_pwr_seq: ordered power-up/down of the cluster domain.
// CLUSTER_PWR_TIMEOUT_EN enables power-good timeouts and ERROR.
module cluster_pwr_seq
   import cluster_pwr_pkg::*;
#(
   parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
   parameter int unsigned ISO_CYCLES     = DEF_ISO_CYCLES,
   parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic cluster_pow_i,
   input  logic cluster_byp_i,
   input  logic cluster_rstn_i,
   input  logic cluster_fetch_enable_i,
   input  logic pwr_good_i,
   output logic cluster_pwr_en_o,
   output logic cluster_iso_o,
   output logic cluster_clk_en_o,
   output logic cluster_rstn_o,
   output logic cluster_fetch_enable_o,
   output logic cluster_busy_o,
   output logic cluster_pwr_err_o
);

   localparam logic [CNT_WIDTH-1:0] ISO_LD =
      CNT_WIDTH'(ISO_CYCLES);
   localparam logic [CNT_WIDTH-1:0] RST_LD =
      CNT_WIDTH'(RST_CYCLES);
   localparam logic [CNT_WIDTH-1:0] TMO_LD =
      CNT_WIDTH'(TIMEOUT_CYCLES);

   cluster_pwr_state_e   state_q, state_d;
   cluster_pwr_out_t     out_q, out_d;
   logic [1:0]           pg_sync_q;
   logic                 pg;
   logic                 req;
   logic                 tmr_load;
   logic [CNT_WIDTH-1:0] tmr_val;
   logic                 tmr_done;

   assign req = cluster_pow_i & ~cluster_byp_i;
   assign pg  = pg_sync_q[1];

   // Two-flop synchroniser for the power switch acknowledge.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         pg_sync_q <= 2'b00;
      end else begin
         pg_sync_q <= {pg_sync_q[0], pwr_good_i};
      end
   end

   // State register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= OFF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: power-up aborts fall into the matching
   // power-down step; power-down always runs to OFF.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OFF: begin
            if (req) state_d = PWR_ON;
         end
         PWR_ON: begin
            if (!req)          state_d = PWR_OFF;
            else if (pg)       state_d = CLK_ON;
`ifdef CLUSTER_PWR_TIMEOUT_EN
            else if (tmr_done) state_d = ERROR;
`endif
         end
         CLK_ON: begin
            if (!req)          state_d = ISO_ON;
            else if (tmr_done) state_d = RST_HOLD;
         end
         RST_HOLD: begin
            if (!req)          state_d = RST_ASSERT;
            else if (tmr_done) state_d = ON;
         end
         ON: begin
            if (!req) state_d = RST_ASSERT;
         end
         RST_ASSERT: begin
            if (tmr_done) state_d = ISO_ON;
         end
         ISO_ON: begin
            if (tmr_done) state_d = PWR_OFF;
         end
         PWR_OFF: begin
            if (!pg)           state_d = OFF;
`ifdef CLUSTER_PWR_TIMEOUT_EN
            else if (tmr_done) state_d = ERROR;
`endif
         end
         ERROR: begin
            if (!req) state_d = OFF;
         end
         default: state_d = OFF;
      endcase
   end

   // Timer reload on every state change, sized by the target.
   always_comb begin
      tmr_load = (state_d != state_q);
      tmr_val  = '0;
      unique case (state_d)
         CLK_ON, ISO_ON:       tmr_val = ISO_LD;
         RST_HOLD, RST_ASSERT: tmr_val = RST_LD;
`ifdef CLUSTER_PWR_TIMEOUT_EN
         PWR_ON, PWR_OFF:      tmr_val = TMO_LD;
`else
         PWR_ON, PWR_OFF:      tmr_val = '0;
`endif
         default:              tmr_val = '0;
      endcase
   end

   cluster_pwr_timer #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_timer (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .load    (tmr_load),
      .value   (tmr_val),
      .done    (tmr_done)
   );

   // Output decode from the next state; in ON the
   // software reset/fetch pass through one flop.
   always_comb begin
      out_d = state_outputs(state_d);
      if (state_d == ON) begin
         out_d.rstn  = cluster_rstn_i;
         out_d.fetch = cluster_fetch_enable_i;
      end
`ifndef CLUSTER_PWR_TIMEOUT_EN
      out_d.err = 1'b0;
`endif
   end

   // Registered outputs, reset to the safe powered-off levels.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         out_q <= OUT_RESET;
      end else begin
         out_q <= out_d;
      end
   end

   assign cluster_pwr_en_o       = out_q.pwr_en;
   assign cluster_iso_o          = out_q.iso;
   assign cluster_clk_en_o       = out_q.clk_en;
   assign cluster_rstn_o         = out_q.rstn;
   assign cluster_fetch_enable_o = out_q.fetch;
   assign cluster_busy_o         = out_q.busy;
   assign cluster_pwr_err_o      = out_q.err;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// tb_cluster_pwr_seq: directed table-driven bench for cluster_pwr_seq.
// Outputs compared as {pwr_en,iso,clk_en,rstn,fetch,busy,err}.
module tb_cluster_pwr_seq;

   logic HCLK = 1'b0;
   logic HRESETn;
   logic pow, byp, rstn_i, fe_i, pg;
   logic pwr_en, iso, clk_en, rstn_o, fe_o, busy, err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         n;
      logic [4:0] in;
      logic [6:0] exp;
      string      name;
   } vec_t;

   vec_t vq[$];

   always #5 HCLK = ~HCLK;

   cluster_pwr_seq dut (
      .HCLK                   (HCLK),
      .HRESETn                (HRESETn),
      .cluster_pow_i          (pow),
      .cluster_byp_i          (byp),
      .cluster_rstn_i         (rstn_i),
      .cluster_fetch_enable_i (fe_i),
      .pwr_good_i             (pg),
      .cluster_pwr_en_o       (pwr_en),
      .cluster_iso_o          (iso),
      .cluster_clk_en_o       (clk_en),
      .cluster_rstn_o         (rstn_o),
      .cluster_fetch_enable_o (fe_o),
      .cluster_busy_o         (busy),
      .cluster_pwr_err_o      (err)
   );

   function automatic logic [6:0] outs();
      return {pwr_en, iso, clk_en, rstn_o, fe_o, busy, err};
   endfunction

   task automatic check(input logic [6:0] exp,
                        input string name);
      logic [6:0] got;
      got = outs();
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, got, exp);
      end
   endtask

   // in = {pow,byp,rstn_i,fe_i,pg}; hold for n edges,
   // then compare on the following falling edge.
   task automatic step(input int n, input logic [4:0] in,
                       input logic [6:0] exp,
                       input string name);
      {pow, byp, rstn_i, fe_i, pg} = in;
      repeat (n) @(posedge HCLK);
      @(negedge HCLK);
      check(exp, name);
   endtask

   task automatic add(input int n, input logic [4:0] in,
                      input logic [6:0] exp,
                      input string name);
      vec_t v;
      v.n = n; v.in = in; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   initial begin
      // full power-up, ON pass-through, full power-down
      add(1, 5'b10100, 7'b1100010, "up_pwr_on");
      add(9, 5'b10100, 7'b1100010, "wait_pg");
      add(2, 5'b10101, 7'b1100010, "pg_sync");
      add(1, 5'b10101, 7'b1110010, "clk_on");
      add(3, 5'b10101, 7'b1110010, "clk_hold");
      add(1, 5'b10101, 7'b1010010, "iso_rel");
      add(7, 5'b10101, 7'b1010010, "rst_hold");
      add(1, 5'b10101, 7'b1011000, "on");
      add(1, 5'b10001, 7'b1010000, "on_rst0");
      add(1, 5'b10111, 7'b1011100, "on_fetch");
      add(1, 5'b00111, 7'b1010010, "rst_assert");
      add(7, 5'b00111, 7'b1010010, "rst_asrt_hold");
      add(1, 5'b00111, 7'b1100010, "iso_on");
      add(3, 5'b00111, 7'b1100010, "iso_hold");
      add(1, 5'b00111, 7'b0100010, "pwr_off");
      add(5, 5'b00111, 7'b0100010, "pg_still_hi");
      add(2, 5'b00110, 7'b0100010, "pg_fall_sync");
      add(1, 5'b00110, 7'b0100000, "off");
      // abort in CLK_ON, re-raise ignored in ISO_ON
      add(1, 5'b10110, 7'b1100010, "s2_pwr_on");
      add(3, 5'b10111, 7'b1110010, "s2_clk_on");
      add(1, 5'b10111, 7'b1110010, "s2_clk_1");
      add(1, 5'b00111, 7'b1100010, "s2_abort_iso");
      add(2, 5'b10111, 7'b1100010, "s2_reraise_ign");
      add(1, 5'b10111, 7'b1100010, "s2_iso_last");
      add(1, 5'b10111, 7'b0100010, "s2_pwr_off");
      add(3, 5'b10111, 7'b0100010, "s2_off_wait");
      add(2, 5'b10110, 7'b0100010, "s2_pg_sync");
      add(1, 5'b10110, 7'b0100000, "s2_off");
      add(1, 5'b10110, 7'b1100010, "s2_restart");
      add(1, 5'b00110, 7'b0100010, "s2_pwron_abort");
      add(1, 5'b00110, 7'b0100000, "s2_off2");
      // bypass masks request; bypass in ON powers down
      add(5, 5'b11110, 7'b0100000, "byp_masks");
      add(1, 5'b10110, 7'b1100010, "s3_pwr_on");
      add(3, 5'b10111, 7'b1110010, "s3_clk_on");
      add(4, 5'b10111, 7'b1010010, "s3_rst_hold");
      add(8, 5'b10111, 7'b1011100, "s3_on");
      add(1, 5'b11111, 7'b1010010, "s3_byp_down");
      add(8, 5'b11111, 7'b1100010, "s3_iso_on");
      add(4, 5'b11111, 7'b0100010, "s3_pwr_off");
      add(3, 5'b11110, 7'b0100000, "s3_off");

      HRESETn = 1'b0;
      {pow, byp, rstn_i, fe_i, pg} = 5'b00100;
      repeat (2) @(negedge HCLK);
      check(7'b0100000, "reset_vals");
      HRESETn = 1'b1;

      foreach (vq[i])
         step(vq[i].n, vq[i].in, vq[i].exp, vq[i].name);

      // asynchronous reset in the middle of RST_HOLD
      step(1, 5'b10110, 7'b1100010, "s4_pwr_on");
      step(3, 5'b10111, 7'b1110010, "s4_clk_on");
      step(4, 5'b10111, 7'b1010010, "s4_rst_hold");
      step(3, 5'b10111, 7'b1010010, "s4_mid_hold");
      #2 HRESETn = 1'b0;
      #1 check(7'b0100000, "async_rst");
      @(posedge HCLK);
      #1 check(7'b0100000, "rst_held");
      @(negedge HCLK);
      HRESETn = 1'b1;
      step(1, 5'b10111, 7'b1100010, "s4_fresh_on");
      step(2, 5'b10111, 7'b1110010, "s4_fresh_clk");

      // bring down, then hold power-good low in PWR_ON
      step(1, 5'b00111, 7'b1100010, "s5_iso_on");
      step(4, 5'b00111, 7'b0100010, "s5_pwr_off");
      step(3, 5'b00110, 7'b0100000, "s5_off");
      step(1, 5'b10110, 7'b1100010, "s5_pwr_on");
      step(199, 5'b10110, 7'b1100010, "s5_wait");
`ifdef CLUSTER_PWR_TIMEOUT_EN
      step(1, 5'b10110, 7'b0100001, "tmo_error");
      step(3, 5'b10110, 7'b0100001, "err_sticky");
      step(1, 5'b00110, 7'b0100000, "err_clear");
`else
      step(1, 5'b10110, 7'b1100010, "no_tmo");
      step(50, 5'b10110, 7'b1100010, "no_tmo_long");
      step(1, 5'b00110, 7'b0100010, "s5_abort");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
